result_reporter: RTL and testbench
==================================

# result_reporter

Downstream of `shapool` in the top level: captures the first winning result (`success`, 32-bit nonce, 8-bit match flags), raises the open-drain READY request, and holds the core stopped. The captured result is then shifted out MSB-first over the daisy-chained SPI(1) link. Each device's shift register forms one link of the chain, so the host reads every device in a single transaction. The core is released only after a complete 40-bit readout.

## Interface
- `NONCE_WIDTH`, default 32: nonce width from `shapool`.
- `FLAGS_WIDTH`, default 8: match-flag width.
- `SYNC_STAGES`, default 2: synchronizer depth on SPI pins, minimum 2.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `sck_in` in 1: SPI(1) clock, asynchronous to `clk`.
- `sdi_in` in 1: SPI(1) data in, from the upstream device or the host.
- `cs_n_in` in 1: SPI(1) chip select, active low.
- `success` in 1: single-cycle result strobe from `shapool`.
- `nonce` in NONCE_WIDTH: winning nonce, valid with `success`.
- `match_flags` in FLAGS_WIDTH: per-hasher match flags, valid with `success`.
- `sdo_out` out 1: SPI(1) data out, to the downstream device.
- `ready` out 1: result waiting; top level drives open-drain low from it.
- `core_run` out 1: high allows the core to run; top level combines it into the core reset.

## Operation
- W = NONCE_WIDTH + FLAGS_WIDTH = 40.
- `result_q` holds {match_flags, nonce}.
- `shreg` is the W-bit shift register. `sdo_out` = `shreg[W-1]`.
- States: ARMED (`ready`=0, `core_run`=1) and CAPTURED (`ready`=1, `core_run`=0).
- ARMED → CAPTURED on `success`; `result_q` loads {match_flags, nonce} on the same edge.
- A `success` while in CAPTURED is ignored; the first result wins.
- A `success` during an active transaction while ARMED is still captured, but that transaction does not clear it.
- cs_n falling edge (synchronized):
  - `shreg` ← `result_q` if in CAPTURED, else all zeros.
  - `loaded_q` ← (state == CAPTURED).
  - `bitcnt` ← 0.
- sck rising edge while cs_n is low: `shreg` ← {`shreg[W-2:0]`, `sdi_sync`}. `bitcnt` increments and saturates at 63 (6 bits).
- sck edges while cs_n is high are ignored; `shreg` holds its value.
- cs_n rising edge: if `loaded_q` and `bitcnt` ≥ W, go CAPTURED → ARMED and clear `loaded_q`. A short transaction (`bitcnt` < W) leaves the state in CAPTURED so the host can retry.
- cs_n falling and sck rising detected on the same cycle: the load takes priority and that sck edge is dropped. The host must not do this.
- Reset values: state ARMED, `result_q`=0, `shreg`=0, `bitcnt`=0, `loaded_q`=0, `ready`=0, `core_run`=1, `sdo_out`=0.
- Reset mid-transaction: state returns to ARMED and the result is discarded. The remainder of that transaction shifts zeros-based data, and the pending cs_n rise has no effect.

## Timing
- `success` at edge N: `ready`=1 and `core_run`=0 from edge N+1 (registered outputs).
- Pin-to-action latency: SYNC_STAGES+1 clk edges (synchronizer plus edge-detect FF). `sdo_out` changes one more edge later.
- Required SPI timing: sck high and low times ≥ SYNC_STAGES+3 clk. cs_n setup/hold to the first/last sck edge ≥ SYNC_STAGES+3 clk.
- Mode 0: the host samples `sdo_out` on the sck rising edge. Data changes within SYNC_STAGES+2 clk after each rising edge, so it is settled before the next rising edge.
- cs_n rise with a full readout: `ready` falls and `core_run` rises SYNC_STAGES+2 edges after the pin change.

## Structure
- Shared package `result_pkg`:
  - constant `RESULT_WIDTH` = 40.
  - `state_t` enum {ARMED, CAPTURED}.
  - constant `BITCNT_WIDTH` = 6.
- Sub-module `sync_edge`: SYNC_STAGES-FF synchronizer plus one delay FF. Outputs `level`, `rise`, `fall`. Instantiated for `sck_in`, `cs_n_in` and `sdi_in` (`sdi_in` uses level only).
- Synchronizer FFs reset to: `cs_n` 1, `sck` 0, `sdi` 0.

## Test plan
- Reset, then `success` with nonce=0xDEADBEEF, flags=0x81 → `ready`=1 and `core_run`=0 next edge. A 40-bit readout returns 0x81DEADBEEF MSB-first; after the cs_n rise, `ready`=0 and `core_run`=1.
- Capture A (nonce 0x00000001), then `success` B (nonce 0x00000002) → readout returns A.
- Result captured, transaction of 20 sck pulses → `ready` stays 1; a following 40-bit readout still returns the full value and clears `ready`.
- Two-device chain with results 0x01_11111111 and 0x02_22222222, 80 sck pulses → the host receives the downstream device's result first, then the upstream device's. Both devices return to ARMED.
- ARMED, readout → 40 zeros returned; state unchanged. `success` mid-transaction → `ready`=1 and stays 1 after the cs_n rise.
- `reset` pulsed during bit 17 of a readout → `ready`=0 and `core_run`=1 next edge; the cs_n rise causes no state change.

Source files
------------

// File: rtl/result_pkg.sv
// result_pkg: shared constants and state encoding for result_reporter.
// Ports: none (package only).
package result_pkg;

    localparam int RESULT_WIDTH = 40;
    localparam int BITCNT_WIDTH = 6;

    typedef enum logic {
        ARMED    = 1'b0,
        CAPTURED = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-FF synchronizer for one async pin plus edge detect.
// Ports: clk, reset (sync, active high), din (async pin);
//        level (synchronized pin), rise / fall (one-cycle edge pulses).
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // STAGES must be at least 2 for metastability settling.
    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/result_reporter.sv
// result_reporter: captures the first winning result, holds the core
// stopped and shifts the result out over a daisy-chained SPI link.
// Ports: clk, reset (sync, active high); sck_in, sdi_in, cs_n_in (SPI pins,
//        async); success, nonce, match_flags (from shapool);
//        sdo_out (to downstream device), ready, core_run.
module result_reporter
    import result_pkg::*;
#(
    parameter int NONCE_WIDTH = 32,
    parameter int FLAGS_WIDTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sck_in,
    input  logic                   sdi_in,
    input  logic                   cs_n_in,
    input  logic                   success,
    input  logic [NONCE_WIDTH-1:0] nonce,
    input  logic [FLAGS_WIDTH-1:0] match_flags,
    output logic                   sdo_out,
    output logic                   ready,
    output logic                   core_run
);

    localparam int W = NONCE_WIDTH + FLAGS_WIDTH;
    localparam logic [BITCNT_WIDTH-1:0] FULL_CNT =
        BITCNT_WIDTH'(W);

    logic sck_rise;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic sdi_sync;
    logic [1:0] sck_other_unused;
    logic [1:0] sdi_edges_unused;

    sync_edge #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b0)
    ) u_sck (
        .clk  (clk),
        .reset(reset),
        .din  (sck_in),
        .level(sck_other_unused[0]),
        .rise (sck_rise),
        .fall (sck_other_unused[1])
    );

    sync_edge #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_cs (
        .clk  (clk),
        .reset(reset),
        .din  (cs_n_in),
        .level(cs_level),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b0)
    ) u_sdi (
        .clk  (clk),
        .reset(reset),
        .din  (sdi_in),
        .level(sdi_sync),
        .rise (sdi_edges_unused[0]),
        .fall (sdi_edges_unused[1])
    );

    state_t                  state_q;
    logic [W-1:0]            result_q;
    logic [W-1:0]            shreg_q;
    logic [BITCNT_WIDTH-1:0] bitcnt_q;
    logic                    loaded_q;
    logic                    ready_q;
    logic                    core_run_q;
    logic                    sdo_q;

    logic shift_en;
    logic release_en;

    // A cs_n fall on the same cycle as an sck rise drops the sck edge.
    assign shift_en   = sck_rise & ~cs_level & ~cs_fall;
    // Only a transaction that began with a loaded result and clocked
    // out every bit may release the core.
    assign release_en = cs_rise & loaded_q & (bitcnt_q >= FULL_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARMED;
            result_q   <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            loaded_q   <= 1'b0;
            ready_q    <= 1'b0;
            core_run_q <= 1'b1;
            sdo_q      <= 1'b0;
        end else begin
            // loaded_q implies CAPTURED, so these never collide.
            if (state_q == ARMED && success) begin
                state_q  <= CAPTURED;
                result_q <= {match_flags, nonce};
            end else if (release_en) begin
                state_q  <= ARMED;
            end

            unique case (1'b1)
                cs_fall: begin
                    shreg_q  <= (state_q == CAPTURED) ? result_q : '0;
                    loaded_q <= (state_q == CAPTURED);
                    bitcnt_q <= '0;
                end
                shift_en: begin
                    shreg_q <= {shreg_q[W-2:0], sdi_sync};
                    if (bitcnt_q != '1)
                        bitcnt_q <= bitcnt_q + 1'b1;
                end
                release_en: begin
                    loaded_q <= 1'b0;
                end
                default: ;
            endcase

            ready_q    <= (state_q == CAPTURED);
            core_run_q <= (state_q == ARMED);
            sdo_q      <= shreg_q[W-1];
        end
    end

    assign sdo_out  = sdo_q;
    assign ready    = ready_q;
    assign core_run = core_run_q;

endmodule

// File: tb/tb_result_reporter.sv
// tb_result_reporter: bench with one standalone device and a two-device
// chain (upstream, downstream) on a shared SPI bus.
module tb_result_reporter;

    localparam int STAGES = 2;
    localparam int H      = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sck;
    logic        cs_n;
    logic        host_sdi;
    logic [2:0]  succ;
    logic [31:0] nonce [3];
    logic [7:0]  flags [3];
    logic [2:0]  sdo;
    logic [2:0]  rdy;
    logic [2:0]  run;

    result_reporter #(.SYNC_STAGES(STAGES)) u_solo (
        .clk(clk), .reset(reset), .sck_in(sck), .sdi_in(host_sdi),
        .cs_n_in(cs_n), .success(succ[0]), .nonce(nonce[0]),
        .match_flags(flags[0]), .sdo_out(sdo[0]), .ready(rdy[0]),
        .core_run(run[0])
    );

    result_reporter #(.SYNC_STAGES(STAGES)) u_up (
        .clk(clk), .reset(reset), .sck_in(sck), .sdi_in(host_sdi),
        .cs_n_in(cs_n), .success(succ[1]), .nonce(nonce[1]),
        .match_flags(flags[1]), .sdo_out(sdo[1]), .ready(rdy[1]),
        .core_run(run[1])
    );

    result_reporter #(.SYNC_STAGES(STAGES)) u_dn (
        .clk(clk), .reset(reset), .sck_in(sck), .sdi_in(sdo[1]),
        .cs_n_in(cs_n), .success(succ[2]), .nonce(nonce[2]),
        .match_flags(flags[2]), .sdo_out(sdo[2]), .ready(rdy[2]),
        .core_run(run[2])
    );

    int tests = 0;
    int fails = 0;

    // Reference model: per device, is a result held, and which one.
    logic        cap [3];
    logic [39:0] val [3];

    int           mid_at;
    logic [2:0]   mid_m;
    logic [119:0] mid_v;
    int           rst_at;
    bit           lat_chk;
    logic [119:0] rx_s;
    logic [119:0] rx_c;

    typedef struct {
        logic        succ;
        logic [39:0] val;
        int          pulses;
        logic [63:0] exp_rx;
        logic        exp_ready;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [2:0] m, input logic [119:0] vv);
        for (int i = 0; i < 3; i++) begin
            nonce[i] = vv[40*i +: 32];
            flags[i] = vv[40*i+32 +: 8];
        end
        succ = m;
        tick(1);
        succ = 3'b000;
        for (int i = 0; i < 3; i++)
            if (m[i] && !cap[i]) begin
                cap[i] = 1'b1;
                val[i] = vv[40*i +: 40];
            end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cap[i] = 1'b0;
        tick(1);
    endtask

    task automatic xfer(input int p);
        logic [39:0]  lv [3];
        logic         ld [3];
        logic [119:0] es;
        logic [119:0] ec;
        for (int i = 0; i < 3; i++) begin
            ld[i] = cap[i];
            lv[i] = cap[i] ? val[i] : 40'h0;
        end
        es   = {lv[0], 80'h0};
        ec   = {lv[2], lv[1], 40'h0};
        rx_s = '0;
        rx_c = '0;
        cs_n = 1'b0;
        tick(H);
        for (int k = 0; k < p; k++) begin
            sck  = 1'b1;
            rx_s = {rx_s[118:0], sdo[0]};
            rx_c = {rx_c[118:0], sdo[2]};
            tick(H);
            if (k == rst_at) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                check("rst_ready", rdy[0], 0);
                check("rst_run", run[0], 1);
                for (int i = 0; i < 3; i++) begin
                    cap[i] = 1'b0;
                    ld[i]  = 1'b0;
                end
            end
            sck = 1'b0;
            if (k == mid_at) strobe(mid_m, mid_v);
            tick(H);
        end
        cs_n = 1'b1;
        if (lat_chk) begin
            tick(STAGES + 1);
            check("rise_hold", rdy[0], 1);
            tick(1);
            check("rise_fall", rdy[0], 0);
            tick(H);
        end else begin
            tick(H + STAGES + 2);
        end
        if (rst_at < 0 && p > 0) begin
            check("model_rx_solo", rx_s, es >> (120 - p));
            check("model_rx_chain", rx_c, ec >> (120 - p));
        end
        for (int i = 0; i < 3; i++) begin
            if (ld[i] && p >= 40) cap[i] = 1'b0;
            check("model_ready", rdy[i], cap[i]);
            check("model_run", run[i], !cap[i]);
        end
    endtask

    initial begin
        logic [127:0] r;
        int           plist [6];
        int           p;
        tbl[0] = '{1'b1, 40'h00_00000001, 0, 64'h0, 1'b1};
        tbl[1] = '{1'b1, 40'h00_00000002, 40, 64'h1, 1'b0};
        tbl[2] = '{1'b1, 40'h5A_12345678, 20, 64'h5A123, 1'b1};
        tbl[3] = '{1'b0, 40'h0, 40, 64'h5A12345678, 1'b0};
        tbl[4] = '{1'b0, 40'h0, 40, 64'h0, 1'b0};
        tbl[5] = '{1'b1, 40'hFF_FFFFFFFF, 39, 64'h7FFFFFFFFF, 1'b1};
        tbl[6] = '{1'b0, 40'h0, 41, 64'h1FFFFFFFFFE, 1'b0};
        plist  = '{0, 5, 39, 40, 41, 80};

        sck      = 1'b0;
        cs_n     = 1'b1;
        host_sdi = 1'b0;
        succ     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            nonce[i] = '0;
            flags[i] = '0;
            cap[i]   = 1'b0;
            val[i]   = '0;
        end
        mid_at  = -1;
        mid_m   = '0;
        mid_v   = '0;
        rst_at  = -1;
        lat_chk = 1'b0;

        do_reset();
        check("reset_ready", rdy[0], 0);
        check("reset_run", run[0], 1);
        check("reset_sdo", sdo[0], 0);

        strobe(3'b001, {80'h0, 40'h81_DEADBEEF});
        check("succ_lat0_ready", rdy[0], 0);
        tick(1);
        check("succ_lat1_ready", rdy[0], 1);
        check("succ_lat1_run", run[0], 0);
        lat_chk = 1'b1;
        xfer(40);
        lat_chk = 1'b0;
        check("deadbeef_rx", rx_s[39:0], 40'h81_DEADBEEF);
        check("deadbeef_run", run[0], 1);

        for (int t = 0; t < 7; t++) begin
            if (tbl[t].succ) strobe(3'b001, {80'h0, tbl[t].val});
            xfer(tbl[t].pulses);
            check("tbl_rx", rx_s[63:0], tbl[t].exp_rx);
            check("tbl_ready", rdy[0], tbl[t].exp_ready);
        end

        strobe(3'b110, {40'h02_22222222, 40'h01_11111111, 40'h0});
        xfer(80);
        check("chain_rx", rx_c[79:0], 80'h0222222222_0111111111);
        check("chain_ready", rdy[2:1], 2'b00);

        mid_at = 10;
        mid_m  = 3'b001;
        mid_v  = {80'h0, 40'hC3_CAFEF00D};
        xfer(40);
        mid_at = -1;
        check("mid_rx", rx_s[39:0], 40'h0);
        check("mid_ready", rdy[0], 1);
        xfer(40);
        check("mid_read_rx", rx_s[39:0], 40'hC3_CAFEF00D);

        strobe(3'b001, {80'h0, 40'h77_89ABCDEF});
        rst_at = 17;
        xfer(40);
        rst_at = -1;
        check("rst_rise_ready", rdy[0], 0);
        check("rst_rise_run", run[0], 1);

        do_reset();
        for (int it = 0; it < 24; it++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            strobe(3'($urandom_range(7)), r[119:0]);
            p = plist[$urandom_range(5)];
            if (p > 0 && $urandom_range(3) == 0) begin
                mid_at = $urandom_range(p - 1);
                mid_m  = 3'($urandom_range(7));
                r      = {$urandom(), $urandom(), $urandom(), $urandom()};
                mid_v  = r[119:0];
            end
            xfer(p);
            mid_at = -1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
